mc_control: RTL and testbench
=============================

MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 Parameter OP_W, default 6: opcode width; supported opcodes occupy the low 6 bits, upper bits must be 0.
REQ-002 Parameter ALUOP_W, default 3, minimum 3: width of alu_op_o; the 3-bit code is zero-extended.
REQ-003 Parameter CNT_W, default 16: width of retired-instruction counter.
REQ-004 clk_i  in  1  sole clock, rising edge.
REQ-005 rst_i  in  1  reset, synchronous, active-high.
REQ-006 instr_op_i  in  OP_W  opcode from instruction register, valid in DECODE.
REQ-007 mem_ready_i  in  1  memory handshake; access completes in a cycle where it is 1.
REQ-008 pc_write_o, pc_write_cond_o, ir_write_o, iord_o, mem_read_o, mem_write_o  out  1 each  PC/IR/memory controls.
REQ-009 reg_write_o, reg_dst_o, mem_to_reg_o, alu_src_a_o, branch_ne_o, jal_o  out  1 each  register-file/ALU/branch controls.
REQ-010 alu_src_b_o  out  2  0=B, 1=const 4, 2=sign-ext imm, 3=imm<<2; pc_src_o  out  2  0=ALU, 1=ALUOut, 2=jump target.
REQ-011 alu_op_o  out  ALUOP_W; state_o  out  3; illegal_o, instr_done_o  out  1 one-cycle pulses; retired_o  out  CNT_W.

Function
REQ-012 FSM states SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, presented on state_o; codes 5-7 SHALL go to FETCH next cycle.
REQ-013 Outputs SHALL be Moore/registered-opcode decoded; every control not named for a state SHALL be 0 in that state.
REQ-014 FETCH: mem_read_o=1, iord_o=0, alu_src_a_o=0, alu_src_b_o=1, alu_op_o=add; ir_write_o=pc_write_o=1 only when mem_ready_i=1, then DECODE; otherwise hold FETCH.
REQ-015 DECODE: opcode registered into op_q; alu_src_b_o=3, alu_op_o=add.
REQ-016 DECODE transitions: j(2) -> pc_write_o=1, pc_src_o=2, FETCH; jal(3) -> additionally reg_write_o=1, jal_o=1; R(0), beq(4), bne(5), addi(8), sltiu(9), ori(13), lui(15), lw(35), sw(43) -> EXEC; any other -> illegal_o=1, FETCH.
REQ-017 ALU codes: R 000, ori 001, addi/lw/sw 010 (add), bne 011, lui 100, beq 110, sltiu 111.
REQ-018 EXEC: alu_src_a_o=1; alu_src_b_o=0 for R/beq/bne, 2 otherwise; R/imm -> WB; lw/sw -> MEM; beq/bne -> pc_write_cond_o=1, pc_src_o=1, branch_ne_o=1 for bne, FETCH.
REQ-019 MEM: iord_o=1; mem_read_o=1 (lw) or mem_write_o=1 (sw); hold until mem_ready_i=1, then lw -> WB, sw -> FETCH.
REQ-020 WB: reg_write_o=1; reg_dst_o=1 for R; mem_to_reg_o=1 for lw; -> FETCH.
REQ-021 instr_done_o SHALL pulse on the cycle an instruction's final state exits to FETCH (j/jal DECODE, branch EXEC, sw MEM, WB); not for illegal opcodes.
REQ-022 retired_o SHALL increment by 1 on each instr_done_o, wrapping from 2^CNT_W-1 to 0.
REQ-023 Latency: j/jal 2 cycles, branch 3, R/imm/sw 4, lw 5, each plus stall cycles with mem_ready_i=0.
REQ-024 instr_op_i changes outside DECODE SHALL NOT affect controls.

Reset
REQ-025 rst_i=1 at a rising edge SHALL force FETCH, op_q=0, retired_o=0, all pulses 0, taking priority over every transition.
REQ-026 Reset mid-MEM SHALL abandon the access; mem_write_o SHALL be 0 from the cycle after the reset edge and the instruction SHALL not count.
REQ-027 While rst_i=1 all control outputs SHALL be 0 except the FETCH-state values after the first edge.

Configuration
REQ-028 Macro MC_CONTROL_JAL_EN defined: jal(3) decoded per REQ-016.
REQ-029 Macro MC_CONTROL_JAL_EN undefined: jal_o tied 0; opcode 3 treated as illegal (illegal_o pulse, no register write, no count).

Verification
REQ-030 Reset then op=0 (R), mem_ready_i=1 -> states 0,1,2,4,0; reg_write_o=1 and reg_dst_o=1 in WB; retired_o=1.
REQ-031 op=35 (lw), mem_ready_i=0 for 3 MEM cycles -> MEM held 4 cycles, mem_read_o=iord_o=1 throughout; mem_to_reg_o=1 in WB.
REQ-032 op=5 (bne) -> EXEC: pc_write_cond_o=1, pc_src_o=1, branch_ne_o=1, alu_op_o=011; instr_done_o pulses once.
REQ-033 op=63 -> illegal_o pulses in DECODE, next state FETCH, retired_o unchanged.
REQ-034 op=43 (sw), rst_i=1 during MEM -> state_o=0, mem_write_o=0 next cycle, retired_o=0.
REQ-035 CNT_W=4, 16 consecutive j instructions -> retired_o wraps 15 to 0; op=3 with MC_CONTROL_JAL_EN undefined -> illegal_o=1.

Source files
------------

// File: rtl/mc_control.sv
// rtl/mc_control.sv - multicycle MIPS-style main control FSM with retired-instruction counter
//
// Purpose: sequences FETCH/DECODE/EXEC/MEM/WB and drives datapath controls
// from the current state and the opcode captured in DECODE.
// Optional feature macro: MC_CONTROL_JAL_EN (decode jal, opcode 3).
//
// Ports:
//   clk_i, rst_i (sync, active-high)   clock and reset
//   instr_op_i [OP_W]                  opcode, sampled only in DECODE
//   mem_ready_i                        memory access completes when 1
//   pc_write_o, pc_write_cond_o, ir_write_o, iord_o, mem_read_o, mem_write_o
//   reg_write_o, reg_dst_o, mem_to_reg_o, alu_src_a_o, branch_ne_o, jal_o
//   alu_src_b_o [2], pc_src_o [2], alu_op_o [ALUOP_W], state_o [3]
//   illegal_o, instr_done_o            one-cycle pulses
//   retired_o [CNT_W]                  count of completed instructions
module mc_control #(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 3,
    parameter int CNT_W   = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [OP_W-1:0]    instr_op_i,
    input  logic               mem_ready_i,
    output logic               pc_write_o,
    output logic               pc_write_cond_o,
    output logic               ir_write_o,
    output logic               iord_o,
    output logic               mem_read_o,
    output logic               mem_write_o,
    output logic               reg_write_o,
    output logic               reg_dst_o,
    output logic               mem_to_reg_o,
    output logic               alu_src_a_o,
    output logic               branch_ne_o,
    output logic               jal_o,
    output logic [1:0]         alu_src_b_o,
    output logic [1:0]         pc_src_o,
    output logic [ALUOP_W-1:0] alu_op_o,
    output logic [2:0]         state_o,
    output logic               illegal_o,
    output logic               instr_done_o,
    output logic [CNT_W-1:0]   retired_o
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        C_ILL, C_R, C_J, C_JAL, C_BEQ, C_BNE, C_IMM, C_LW, C_SW
    } cls_t;

    localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(3'b010);

    // Full-width compare so any set bit above the low six makes the opcode illegal.
    function automatic cls_t classify(input logic [OP_W-1:0] op);
        cls_t c;
        case (op)
            OP_W'(0):  c = C_R;
            OP_W'(2):  c = C_J;
`ifdef MC_CONTROL_JAL_EN
            OP_W'(3):  c = C_JAL;
`endif
            OP_W'(4):  c = C_BEQ;
            OP_W'(5):  c = C_BNE;
            OP_W'(8):  c = C_IMM;
            OP_W'(9):  c = C_IMM;
            OP_W'(13): c = C_IMM;
            OP_W'(15): c = C_IMM;
            OP_W'(35): c = C_LW;
            OP_W'(43): c = C_SW;
            default:   c = C_ILL;
        endcase
        return c;
    endfunction

    function automatic logic [2:0] alu_code(input logic [OP_W-1:0] op);
        logic [2:0] a;
        case (op)
            OP_W'(0):  a = 3'b000;
            OP_W'(13): a = 3'b001;
            OP_W'(5):  a = 3'b011;
            OP_W'(15): a = 3'b100;
            OP_W'(4):  a = 3'b110;
            OP_W'(9):  a = 3'b111;
            default:   a = 3'b010;
        endcase
        return a;
    endfunction

    state_t          state;
    state_t          state_next;
    logic [OP_W-1:0] op_q;
    logic [2:0]      dec_state;
    cls_t            dec_cls;
    cls_t            op_cls;

    assign dec_cls = classify(instr_op_i);
    assign op_cls  = classify(op_q);
    assign state_o = state;

    // While reset is held, any state other than FETCH decodes as an unused
    // code so every control drops to 0 (an in-flight store is abandoned).
    assign dec_state = (rst_i && state != S_FETCH) ? 3'd7 : state;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= S_FETCH;
            op_q      <= '0;
            retired_o <= '0;
        end else begin
            state <= state_next;
            if (state == S_DECODE) begin
                op_q <= instr_op_i;
            end
            if (instr_done_o) begin
                retired_o <= retired_o + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_next      = S_FETCH;
        pc_write_o      = 1'b0;
        pc_write_cond_o = 1'b0;
        ir_write_o      = 1'b0;
        iord_o          = 1'b0;
        mem_read_o      = 1'b0;
        mem_write_o     = 1'b0;
        reg_write_o     = 1'b0;
        reg_dst_o       = 1'b0;
        mem_to_reg_o    = 1'b0;
        alu_src_a_o     = 1'b0;
        branch_ne_o     = 1'b0;
        jal_o           = 1'b0;
        alu_src_b_o     = 2'd0;
        pc_src_o        = 2'd0;
        alu_op_o        = '0;
        illegal_o       = 1'b0;
        instr_done_o    = 1'b0;

        case (dec_state)
            S_FETCH: begin
                mem_read_o  = 1'b1;
                alu_src_b_o = 2'd1;
                alu_op_o    = ALU_ADD;
                state_next  = S_FETCH;
                if (mem_ready_i) begin
                    ir_write_o = 1'b1;
                    pc_write_o = 1'b1;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b_o = 2'd3;
                alu_op_o    = ALU_ADD;
                case (dec_cls)
                    C_J, C_JAL: begin
                        pc_write_o   = 1'b1;
                        pc_src_o     = 2'd2;
                        instr_done_o = 1'b1;
                        reg_write_o  = (dec_cls == C_JAL);
                        jal_o        = (dec_cls == C_JAL);
                    end
                    C_ILL:   illegal_o  = 1'b1;
                    default: state_next = S_EXEC;
                endcase
            end
            S_EXEC: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = ALUOP_W'(alu_code(op_q));
                case (op_cls)
                    C_R: state_next = S_WB;
                    C_BEQ, C_BNE: begin
                        pc_write_cond_o = 1'b1;
                        pc_src_o        = 2'd1;
                        branch_ne_o     = (op_cls == C_BNE);
                        instr_done_o    = 1'b1;
                    end
                    C_LW, C_SW: begin
                        alu_src_b_o = 2'd2;
                        state_next  = S_MEM;
                    end
                    default: begin
                        alu_src_b_o = 2'd2;
                        state_next  = S_WB;
                    end
                endcase
            end
            S_MEM: begin
                iord_o      = 1'b1;
                mem_read_o  = (op_cls == C_LW);
                mem_write_o = (op_cls == C_SW);
                state_next  = S_MEM;
                if (mem_ready_i) begin
                    if (op_cls == C_SW) begin
                        instr_done_o = 1'b1;
                        state_next   = S_FETCH;
                    end else begin
                        state_next = S_WB;
                    end
                end
            end
            S_WB: begin
                reg_write_o  = 1'b1;
                reg_dst_o    = (op_cls == C_R);
                mem_to_reg_o = (op_cls == C_LW);
                instr_done_o = 1'b1;
            end
            default: state_next = S_FETCH;
        endcase

        // Reset wins over every transition: no writes into PC/IR, no pulses.
        if (rst_i) begin
            ir_write_o   = 1'b0;
            pc_write_o   = 1'b0;
            illegal_o    = 1'b0;
            instr_done_o = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_control.sv
// tb/tb_mc_control.sv - self-checking bench for mc_control with instruction-level reference model
module tb_mc_control;

    localparam int OP_W    = 8;
    localparam int ALUOP_W = 4;
    localparam int CNT_W   = 4;

    localparam int P_F = 0, P_D = 1, P_E = 2, P_M = 3, P_W = 4;
    localparam int K_ILL = 0, K_R = 1, K_J = 2, K_JAL = 3, K_BR = 4, K_IMM = 5, K_LW = 6, K_SW = 7;
    localparam int LEGAL [11] = '{0, 2, 3, 4, 5, 8, 9, 13, 15, 35, 43};

    logic               clk = 1'b0;
    logic               rst_i = 1'b1;
    logic               mem_ready_i = 1'b0;
    logic [OP_W-1:0]    instr_op_i = '0;
    logic               pc_write_o, pc_write_cond_o, ir_write_o, iord_o, mem_read_o, mem_write_o;
    logic               reg_write_o, reg_dst_o, mem_to_reg_o, alu_src_a_o, branch_ne_o, jal_o;
    logic [1:0]         alu_src_b_o, pc_src_o;
    logic [ALUOP_W-1:0] alu_op_o;
    logic [2:0]         state_o;
    logic               illegal_o, instr_done_o;
    logic [CNT_W-1:0]   retired_o;

    always #5 clk = ~clk;

    mc_control #(.OP_W(OP_W), .ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst_i), .instr_op_i(instr_op_i), .mem_ready_i(mem_ready_i),
        .pc_write_o(pc_write_o), .pc_write_cond_o(pc_write_cond_o), .ir_write_o(ir_write_o),
        .iord_o(iord_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
        .reg_write_o(reg_write_o), .reg_dst_o(reg_dst_o), .mem_to_reg_o(mem_to_reg_o),
        .alu_src_a_o(alu_src_a_o), .branch_ne_o(branch_ne_o), .jal_o(jal_o),
        .alu_src_b_o(alu_src_b_o), .pc_src_o(pc_src_o), .alu_op_o(alu_op_o),
        .state_o(state_o), .illegal_o(illegal_o), .instr_done_o(instr_done_o),
        .retired_o(retired_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the current instruction is a list of phases; the
    // opcode is chosen when FETCH completes.
    int  phases[$];
    int  ph;
    int  cur_op;
    int  exp_ret;
    int  op_feed[$];
    bit  chk_en = 1'b0;
    int  e_pcw, e_pcwc, e_irw, e_iord, e_mrd, e_mwr, e_rw, e_rd, e_m2r;
    int  e_asa, e_bne, e_jal, e_asb, e_pcs, e_alu, e_st, e_ill, e_done, e_ret;

    function automatic int kind(input int op);
        case (op)
            0:             return K_R;
            2:             return K_J;
`ifdef MC_CONTROL_JAL_EN
            3:             return K_JAL;
`endif
            4, 5:          return K_BR;
            8, 9, 13, 15:  return K_IMM;
            35:            return K_LW;
            43:            return K_SW;
            default:       return K_ILL;
        endcase
    endfunction

    function automatic int alu_of(input int op);
        case (op)
            0:       return 0;
            13:      return 1;
            5:       return 3;
            15:      return 4;
            4:       return 6;
            9:       return 7;
            default: return 2;
        endcase
    endfunction

    function automatic int rand_op();
        if ($urandom_range(0, 9) < 8) return LEGAL[$urandom_range(0, 10)];
        return int'($urandom_range(0, 255));
    endfunction

    task automatic start_instr();
        phases.delete();
        phases.push_back(P_F);
        ph = 0;
        cur_op = -1;
    endtask

    task automatic fetch_done();
        int k;
        cur_op = (op_feed.size() > 0) ? op_feed.pop_front() : rand_op();
        k = kind(cur_op);
        phases.push_back(P_D);
        if (k == K_R || k == K_IMM || k == K_BR || k == K_LW || k == K_SW) phases.push_back(P_E);
        if (k == K_LW || k == K_SW) phases.push_back(P_M);
        if (k == K_R || k == K_IMM || k == K_LW) phases.push_back(P_W);
        ph = 1;
    endtask

    task automatic compute_expected();
        int p;
        int k;
        p = phases[ph];
        k = kind(cur_op);
        {e_pcw, e_pcwc, e_irw, e_iord, e_mrd, e_mwr, e_rw, e_rd, e_m2r} = '0;
        {e_asa, e_bne, e_jal, e_asb, e_pcs, e_alu, e_ill, e_done} = '0;
        e_st  = p;
        e_ret = exp_ret;
        if (!(rst_i && p != P_F)) begin
            case (p)
                P_F: begin
                    e_mrd = 1; e_asb = 1; e_alu = 2;
                    if (mem_ready_i) begin e_irw = 1; e_pcw = 1; end
                end
                P_D: begin
                    e_asb = 3; e_alu = 2;
                    if (k == K_J || k == K_JAL) begin e_pcw = 1; e_pcs = 2; e_done = 1; end
                    if (k == K_JAL) begin e_rw = 1; e_jal = 1; end
                    if (k == K_ILL) e_ill = 1;
                end
                P_E: begin
                    e_asa = 1;
                    e_alu = alu_of(cur_op);
                    e_asb = (k == K_R || k == K_BR) ? 0 : 2;
                    if (k == K_BR) begin
                        e_pcwc = 1; e_pcs = 1; e_done = 1;
                        e_bne = (cur_op == 5) ? 1 : 0;
                    end
                end
                P_M: begin
                    e_iord = 1;
                    e_mrd  = (k == K_LW) ? 1 : 0;
                    e_mwr  = (k == K_SW) ? 1 : 0;
                    e_done = (k == K_SW && mem_ready_i) ? 1 : 0;
                end
                default: begin
                    e_rw = 1; e_done = 1;
                    e_rd  = (k == K_R) ? 1 : 0;
                    e_m2r = (k == K_LW) ? 1 : 0;
                end
            endcase
        end
        if (rst_i) begin e_irw = 0; e_pcw = 0; e_ill = 0; e_done = 0; end
    endtask

    task automatic drive(input bit r, input bit rdy);
        rst_i       = r;
        mem_ready_i = rdy;
        instr_op_i  = (phases[ph] == P_D) ? OP_W'(cur_op) : OP_W'($urandom);
        compute_expected();
        @(negedge clk);
    endtask

    task automatic tick();
        int p;
        @(posedge clk);
        p = phases[ph];
        if (rst_i) begin
            exp_ret = 0;
            start_instr();
        end else if (p == P_F) begin
            if (mem_ready_i) fetch_done();
        end else if (!(p == P_M && !mem_ready_i)) begin
            if (ph == phases.size() - 1) begin
                if (kind(cur_op) != K_ILL) exp_ret = (exp_ret + 1) % (1 << CNT_W);
                start_instr();
            end else begin
                ph++;
            end
        end
        #1;
    endtask

    task automatic cyc(input bit r, input bit rdy);
        drive(r, rdy);
        tick();
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("state_o", state_o, e_st);
            check("pc_write_o", pc_write_o, e_pcw);
            check("pc_write_cond_o", pc_write_cond_o, e_pcwc);
            check("ir_write_o", ir_write_o, e_irw);
            check("iord_o", iord_o, e_iord);
            check("mem_read_o", mem_read_o, e_mrd);
            check("mem_write_o", mem_write_o, e_mwr);
            check("reg_write_o", reg_write_o, e_rw);
            check("reg_dst_o", reg_dst_o, e_rd);
            check("mem_to_reg_o", mem_to_reg_o, e_m2r);
            check("alu_src_a_o", alu_src_a_o, e_asa);
            check("branch_ne_o", branch_ne_o, e_bne);
            check("jal_o", jal_o, e_jal);
            check("alu_src_b_o", alu_src_b_o, e_asb);
            check("pc_src_o", pc_src_o, e_pcs);
            check("alu_op_o", alu_op_o, e_alu);
            check("illegal_o", illegal_o, e_ill);
            check("instr_done_o", instr_done_o, e_done);
            check("retired_o", retired_o, e_ret);
        end
    end

    localparam int R_ST  [5] = '{0, 1, 2, 4, 0};
    localparam int R_RDY [5] = '{1, 1, 1, 1, 0};
    localparam int LW_ST [9] = '{0, 1, 2, 3, 3, 3, 3, 4, 0};
    localparam int LW_RDY[9] = '{1, 1, 1, 0, 0, 0, 1, 1, 0};

    initial begin
        int dones;
        int ret_after_op3;

        @(posedge clk);
        #1;
        start_instr();
        exp_ret = 0;
        chk_en  = 1'b1;

        drive(1, 1);
        check("reset_state", state_o, 0);
        check("reset_retired", retired_o, 0);
        check("reset_ir_write", ir_write_o, 0);
        tick();

        op_feed.push_back(0);
        for (int i = 0; i < 5; i++) begin
            drive(0, R_RDY[i] != 0);
            check("r_state", state_o, R_ST[i]);
            if (i == 3) begin
                check("r_wb_reg_write", reg_write_o, 1);
                check("r_wb_reg_dst", reg_dst_o, 1);
            end
            if (i == 4) check("r_retired", retired_o, 1);
            tick();
        end

        op_feed.push_back(35);
        for (int i = 0; i < 9; i++) begin
            drive(0, LW_RDY[i] != 0);
            check("lw_state", state_o, LW_ST[i]);
            if (i >= 3 && i <= 6) begin
                check("lw_mem_read", mem_read_o, 1);
                check("lw_iord", iord_o, 1);
            end
            if (i == 7) check("lw_mem_to_reg", mem_to_reg_o, 1);
            if (i == 8) check("lw_retired", retired_o, 2);
            tick();
        end

        op_feed.push_back(5);
        dones = 0;
        for (int i = 0; i < 4; i++) begin
            drive(0, i < 3);
            dones += int'(instr_done_o);
            if (i == 2) begin
                check("bne_pc_write_cond", pc_write_cond_o, 1);
                check("bne_pc_src", pc_src_o, 1);
                check("bne_branch_ne", branch_ne_o, 1);
                check("bne_alu_op", alu_op_o, 3);
            end
            if (i == 3) check("bne_retired", retired_o, 3);
            tick();
        end
        check("bne_done_pulses", dones, 1);

        op_feed.push_back(63);
        for (int i = 0; i < 3; i++) begin
            drive(0, i < 2);
            if (i == 1) check("illegal_pulse", illegal_o, 1);
            if (i == 2) begin
                check("illegal_next_state", state_o, 0);
                check("illegal_retired", retired_o, 3);
            end
            tick();
        end

        op_feed.push_back(43);
        for (int i = 0; i < 5; i++) begin
            drive(i == 3, i < 3);
            if (i == 3) check("sw_in_mem", state_o, 3);
            if (i == 4) begin
                check("sw_rst_state", state_o, 0);
                check("sw_rst_mem_write", mem_write_o, 0);
                check("sw_rst_retired", retired_o, 0);
            end
            tick();
        end

        op_feed.push_back(3);
`ifdef MC_CONTROL_JAL_EN
        ret_after_op3 = 1;
`else
        ret_after_op3 = 0;
`endif
        for (int i = 0; i < 3; i++) begin
            drive(0, i < 2);
`ifdef MC_CONTROL_JAL_EN
            if (i == 1) check("op3_jal", jal_o, 1);
`else
            if (i == 1) check("op3_illegal", illegal_o, 1);
`endif
            if (i == 2) check("op3_retired", retired_o, ret_after_op3);
            tick();
        end

        cyc(1, 0);
        for (int n = 0; n < 16; n++) begin
            op_feed.push_back(2);
            cyc(0, 1);
            cyc(0, 1);
            if (n == 14) begin
                drive(0, 0);
                check("wrap_at_15", retired_o, 15);
                tick();
            end
        end
        drive(0, 0);
        check("wrap_to_0", retired_o, 0);
        tick();

        for (int c = 0; c < 3000; c++) begin
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0);
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
